pdecoder_4to16_accum: RTL and testbench
=======================================

Name: pdecoder_4to16_accum

Overview:
- Inverse of the 16-to-4 priority-encoder path: rebuilds a 16-bit bitmask from a stream of 4-bit set-bit indices.
- Sits at the consumer end of the sparse bit-serial datapath and restores the bitmask for writeback and checking.
- A valid/ready input stream delivers one index per beat and closes each mask with in_last.
- Each completed mask is held on a valid/ready output until it is taken.

Parameters:
- NUM_BITS, 16, mask width; fixed at 16 in this revision.
- IDX_W, 4, index width, equal to log2(NUM_BITS).
- CNT_W, 5, population-count width, equal to IDX_W+1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  index beat valid
- in_ready  output  1  block can accept a beat
- in_idx  input  4  set-bit position; value k sets out_mask[k]
- in_zero  input  1  beat carries no index; in_idx is ignored
- in_last  input  1  final beat of the current mask
- out_valid  output  1  reconstructed mask valid
- out_ready  input  1  downstream accepts the mask
- out_mask  output  16  reconstructed bitmask
- out_count  output  5  number of distinct set bits in out_mask (0..16)
- dup_err  output  1  present only with PDEC_DUP_CHECK_EN

Behaviour:
- Reset: synchronous, active-high.
  - State returns to ACCUM; the accumulator and count clear.
  - out_valid=0, out_mask=0, out_count=0, dup_err=0. in_ready=1 in the first cycle after reset.
  - Reset mid-mask discards the partial accumulation.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
  - If in_zero=0: acc |= onehot(in_idx). cnt increments only if that bit was previously 0, so repeated indices are idempotent.
  - If in_zero=1: acc and cnt are unchanged.
- ACCUM -> HOLD on an accepted beat with in_last=1:
  - out_mask <= acc | onehot(in_idx), with the onehot term masked off when in_zero=1.
  - out_count <= the updated count.
  - acc and cnt clear in the same edge.
- Latency: out_valid rises the cycle after the last beat is accepted (1 cycle).
- HOLD -> ACCUM when out_ready=1. out_valid drops the next cycle.
  - out_mask and out_count keep their last values; they are don't-care while out_valid=0.
- No overlap: the next mask's first beat is accepted no earlier than the cycle after the handshake. A single-beat mask therefore costs 2 cycles minimum.
- out_mask and out_count are stable while out_valid=1 && out_ready=0.
- Corner cases:
  - A mask made of a single in_zero+in_last beat yields out_mask=0 and out_count=0.
  - All 16 indices delivered yields out_mask=16'hFFFF and out_count=16; no overflow is possible because cnt saturates by construction.
  - in_valid with in_ready=0 is stalled; the source must hold the beat.
  - in_idx changes while in_zero=1 have no effect.

Optional Feature:
- Macro: PDEC_DUP_CHECK_EN.
- Defined:
  - dup_err port exists. A sticky per-mask flag sets on any accepted non-zero beat whose bit is already set in acc.
  - The flag is registered alongside out_mask, valid in HOLD, and cleared at the HOLD->ACCUM handshake and on reset.
  - Duplicates are still merged into the mask (OR).
- Undefined: no dup_err port and no flag logic; duplicates are silently merged.

Decomposition:
- Shared package pdec_pkg:
  - NUM_BITS, IDX_W, CNT_W localparams.
  - pdec_state_t enum {ACCUM, HOLD}.
  - onehot16 function.
- Sub-module: pdecoder_4to16, combinational, in_idx + en -> 16-bit onehot. The top instantiates one copy.

Test Plan:
- Reset, then beats idx 3, 7, 15 (last on 15) with out_ready=1 -> out_valid one cycle after the last beat; out_mask=16'h8088, out_count=3; in_ready returns to 1 the following cycle.
- Single beat in_zero=1, in_last=1 -> out_mask=16'h0000, out_count=0, out_valid asserted for exactly one cycle.
- idx 0..15 ascending, last on 15, out_ready held 0 for 5 cycles -> out_mask=16'hFFFF and out_count=16 stable throughout; in_ready=0 during the stall; in_valid beats presented meanwhile are not accepted.
- Beats 5, 5, 2 (last) -> out_mask=16'h0024, out_count=2; with PDEC_DUP_CHECK_EN, dup_err=1. A following mask of idx 1 (last) -> dup_err=0, out_mask=16'h0002.
- Reset asserted after beats 4, 9 with no last, then beat 1 with last -> out_mask=16'h0002, out_count=1; no residue of 4 or 9.
- Random back-to-back masks (random beat counts and in_zero insertion, random out_ready) -> each out_mask equals the reference OR of its beats and out_count equals its popcount.

Source files
------------

// File: rtl/pdec_pkg.sv
// Shared types and helpers for the 4-to-16 index-to-bitmask accumulator.
package pdec_pkg;

  localparam int NUM_BITS = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = IDX_W + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } pdec_state_t;

  function automatic logic [NUM_BITS-1:0] onehot16(input logic [IDX_W-1:0] idx);
    logic [NUM_BITS-1:0] one;
    one = {{(NUM_BITS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/pdecoder_4to16.sv
// Combinational 4-to-16 decoder with enable; all-zero output when disabled.
module pdecoder_4to16
  import pdec_pkg::*;
(
  input  logic [IDX_W-1:0]    idx_i,
  input  logic                en_i,
  output logic [NUM_BITS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o = onehot16(idx_i);
  end

endmodule

// File: rtl/pdecoder_4to16_accum.sv
// Rebuilds a 16-bit mask from a stream of set-bit indices and holds it until taken.
// Optional duplicate-index flag (dup_err) enabled by defining PDEC_DUP_CHECK_EN.
module pdecoder_4to16_accum
  import pdec_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic                in_zero,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_mask,
  output logic [CNT_W-1:0]    out_count
`ifdef PDEC_DUP_CHECK_EN
  ,
  output logic                dup_err
`endif
);

  pdec_state_t         state_q, state_d;
  logic [NUM_BITS-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [NUM_BITS-1:0] onehot;
  logic [NUM_BITS-1:0] acc_upd;
  logic [CNT_W-1:0]    cnt_upd;
  logic                new_bit;
  logic                accept;

  pdecoder_4to16 u_dec (
    .idx_i    (in_idx),
    .en_i     (~in_zero),
    .onehot_o (onehot)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_mask  = mask_q;
  assign out_count = count_q;

  assign accept  = in_valid && in_ready;
  // Count only bits that were previously clear so repeats are idempotent.
  assign new_bit = |(onehot & ~acc_q);
  assign acc_upd = acc_q | onehot;
  assign cnt_upd = cnt_q + {{(CNT_W-1){1'b0}}, new_bit};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    count_d = count_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (in_last) begin
            mask_d  = acc_upd;
            count_d = cnt_upd;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = acc_upd;
            cnt_d = cnt_upd;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

`ifdef PDEC_DUP_CHECK_EN
  logic dacc_q, dacc_d;
  logic dup_q, dup_d;
  logic dup_hit;

  assign dup_hit = |(onehot & acc_q);
  assign dup_err = dup_q;

  // Sticky per-mask flag, latched into the output register with the mask.
  always_comb begin
    dacc_d = dacc_q;
    dup_d  = dup_q;
    if (accept) begin
      if (in_last) begin
        dup_d  = dacc_q | dup_hit;
        dacc_d = 1'b0;
      end else begin
        dacc_d = dacc_q | dup_hit;
      end
    end else if (out_valid && out_ready) begin
      dup_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dacc_q <= 1'b0;
      dup_q  <= 1'b0;
    end else begin
      dacc_q <= dacc_d;
      dup_q  <= dup_d;
    end
  end
`endif

endmodule

// File: tb/tb_pdecoder_4to16_accum.sv
// Directed self-checking bench for pdecoder_4to16_accum.
module tb_pdecoder_4to16_accum;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_idx;
  logic        in_zero;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mask;
  logic [4:0]  out_count;
`ifdef PDEC_DUP_CHECK_EN
  logic        dup_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pdecoder_4to16_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_zero   (in_zero),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count)
`ifdef PDEC_DUP_CHECK_EN
    ,
    .dup_err   (dup_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted (bounded).
  task automatic beat(input logic [3:0] idx, input logic z, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_idx   = idx;
    in_zero  = z;
    in_last  = l;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("beat_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_zero  = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for a mask, compare it, then complete the handshake.
  task automatic take(input string tag, input logic [15:0] em, input logic [4:0] ec, input int stall);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_mask"}, {16'd0, out_mask}, {16'd0, em});
    check({tag, "_count"}, {27'd0, out_count}, {27'd0, ec});
    out_ready = 1'b0;
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] ref_mask;
    int nb;
    logic [3:0] ri;
    logic rz;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_idx    = '0;
    in_zero   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mask", {16'd0, out_mask}, 32'd0);
    check("rst_count", {27'd0, out_count}, 32'd0);
`ifdef PDEC_DUP_CHECK_EN
    check("rst_dup", {31'd0, dup_err}, 32'd0);
`endif

    // Basic mask 3,7,15 with out_ready already high.
    out_ready = 1'b1;
    beat(4'd3, 1'b0, 1'b0);
    beat(4'd7, 1'b0, 1'b0);
    beat(4'd15, 1'b0, 1'b1);
    check("t1_latency", {31'd0, out_valid}, 32'd1);
    check("t1_mask", {16'd0, out_mask}, 32'h8088);
    check("t1_count", {27'd0, out_count}, 32'd3);
    check("t1_in_ready_hold", {31'd0, in_ready}, 32'd0);
    tick();
    check("t1_out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t1_in_ready_back", {31'd0, in_ready}, 32'd1);

    // Single zero+last beat: empty mask, valid for exactly one cycle.
    beat(4'd9, 1'b1, 1'b1);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_mask", {16'd0, out_mask}, 32'h0000);
    check("t2_count", {27'd0, out_count}, 32'd0);
    tick();
    check("t2_one_cycle", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Full mask with a 5-cycle downstream stall and a beat pushed meanwhile.
    for (int i = 0; i < 16; i++) beat(4'(i), 1'b0, (i == 15));
    in_valid = 1'b1;
    in_idx   = 4'd0;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      check("t3_stall_ready", {31'd0, in_ready}, 32'd0);
      check("t3_stall_mask", {16'd0, out_mask}, 32'hFFFF);
      check("t3_stall_count", {27'd0, out_count}, 32'd16);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_drop", {31'd0, out_valid}, 32'd0);

    // Duplicate merging; a stalled beat from above must not leak in.
    beat(4'd5, 1'b0, 1'b0);
    beat(4'd5, 1'b0, 1'b0);
    beat(4'd2, 1'b0, 1'b1);
`ifdef PDEC_DUP_CHECK_EN
    check("t4_dup_set", {31'd0, dup_err}, 32'd1);
`endif
    take("t4", 16'h0024, 5'd2, 2);
    beat(4'd1, 1'b0, 1'b1);
`ifdef PDEC_DUP_CHECK_EN
    check("t4b_dup_clr", {31'd0, dup_err}, 32'd0);
`endif
    take("t4b", 16'h0002, 5'd1, 0);

    // Reset mid-mask discards the partial accumulation.
    beat(4'd4, 1'b0, 1'b0);
    beat(4'd9, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
    beat(4'd1, 1'b0, 1'b1);
    take("t5", 16'h0002, 5'd1, 0);

    // Pseudo-random back-to-back masks against an OR/popcount reference.
    for (int m = 0; m < 20; m++) begin
      ref_mask = '0;
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        ri = 4'($urandom_range(0, 15));
        rz = ($urandom_range(0, 3) == 0);
        if (!rz) ref_mask[ri] = 1'b1;
        beat(ri, rz, (b == nb - 1));
      end
      take("rand", ref_mask, 5'($countones(ref_mask)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
